// File: rtl/serial_adder_ctrl.sv
// Sequencer for one bit-serial add/subtract: loads two external PISO shift registers,
// full-adds their LSB-first bit streams through a carry flop, and returns the word with flags.
module serial_adder_ctrl #(
    parameter int WORDWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORDWIDTH-1:0] op_a,
    input  logic [WORDWIDTH-1:0] op_b,
    input  logic                 op_sub,
    output logic                 sr_load,
    output logic [WORDWIDTH-1:0] sr_data_a,
    output logic [WORDWIDTH-1:0] sr_data_b,
    input  logic                 sr_bit_a,
    input  logic                 sr_bit_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORDWIDTH-1:0] sum,
    output logic                 carry_out,
    output logic                 overflow,
    output logic                 busy
);

    localparam int CW = (WORDWIDTH > 2) ? $clog2(WORDWIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDWIDTH - 1);

    typedef enum logic [2:0] {IDLE, LOAD, PRIME, SHIFT, HOLD} state_t;

    state_t               state, state_nxt;
    logic [WORDWIDTH-1:0] a_q, b_q, sh_q, sum_q;
    logic                 sub_q, carry_q, cout_q, ovf_q;
    logic [CW-1:0]        cnt_q;
    logic                 b_eff, s_bit, c_nxt, last_bit;

    always_comb begin
        b_eff    = sr_bit_b ^ sub_q;
        s_bit    = sr_bit_a ^ b_eff ^ carry_q;
        c_nxt    = (sr_bit_a & b_eff) | (sr_bit_a & carry_q) | (b_eff & carry_q);
        last_bit = (cnt_q == LAST);
    end

    // Both handshakes transfer on a clock edge where valid and ready are high together;
    // in_ready is high only in IDLE and out_valid only in HOLD, so the two never overlap.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = LOAD;
            LOAD:    state_nxt = PRIME;
            PRIME:   state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= op_a;
                        b_q   <= op_b;
                        sub_q <= op_sub;
                    end
                end
                PRIME: begin
                    // Subtract is A + ~B + 1: the +1 enters as the initial carry.
                    carry_q <= sub_q;
                    cnt_q   <= '0;
                end
                SHIFT: begin
                    carry_q <= c_nxt;
                    sh_q    <= {s_bit, sh_q[WORDWIDTH-1:1]};
                    if (!last_bit) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        // Published word and flags change only here, so they hold between ops.
                        sum_q  <= {s_bit, sh_q[WORDWIDTH-1:1]};
                        cout_q <= c_nxt;
                        ovf_q  <= carry_q ^ c_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign sr_load   = (state == LOAD);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign sr_data_a = a_q;
    assign sr_data_b = b_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: vector table, hand-written corner sequences and random ops
// checked against an arithmetic reference model; shift registers are modelled inline.
module tb_serial_adder_ctrl;

    localparam int W  = 8;
    localparam int RW = W + 2;

    logic         clk, rst;
    logic         in_valid, in_ready, op_sub;
    logic [W-1:0] op_a, op_b;
    logic         sr_load, sr_bit_a, sr_bit_b;
    logic [W-1:0] sr_data_a, sr_data_b;
    logic         out_valid, out_ready;
    logic [W-1:0] sum;
    logic         carry_out, overflow, busy;
    logic         rst_n;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    logic [RW-1:0] exp_q[$];

    serial_adder_ctrl #(.WORDWIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
        .sr_load(sr_load), .sr_data_a(sr_data_a), .sr_data_b(sr_data_b),
        .sr_bit_a(sr_bit_a), .sr_bit_b(sr_bit_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .overflow(overflow), .busy(busy)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Two PISO shift registers: load captures at the edge, otherwise out <= memory[0] and shift.
    assign rst_n = ~rst;
    logic [W-1:0] mem_a, mem_b;

    always @(posedge clk) begin
        if (!rst_n) begin
            mem_a <= '0; mem_b <= '0; sr_bit_a <= 1'b0; sr_bit_b <= 1'b0;
        end else if (sr_load) begin
            mem_a <= sr_data_a; mem_b <= sr_data_b;
        end else begin
            sr_bit_a <= mem_a[0]; sr_bit_b <= mem_b[0];
            mem_a <= mem_a >> 1;  mem_b <= mem_b >> 1;
        end
    end

    // Reference model: plain integer arithmetic on the operands.
    function automatic void model(input logic [W-1:0] a, b, input logic sub,
                                  output logic [W-1:0] s, output logic c, v);
        int u, r;
        u = sub ? (int'(a) - int'(b)) : (int'(a) + int'(b));
        r = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
        s = u[W-1:0];
        c = sub ? (u >= 0) : (u > 255);
        v = (r > 127) || (r < -128);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Called at the negedge of accept cycle t0 + 1; returns at the first out_valid negedge.
    task automatic wait_result(input int t0, input logic [W-1:0] es, input logic ec, ev,
                               input string name);
        int nload, load_at, lat;
        nload = 0; load_at = -1; lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (sr_load) begin nload++; load_at = cyc - t0; end
            if (out_valid) begin lat = cyc - t0; break; end
            @(negedge clk);
        end
        check({name, " latency"},    lat, W + 3);
        check({name, " load count"}, nload, 1);
        check({name, " load cycle"}, load_at, 1);
        check({name, " sum"},        sum, es);
        check({name, " carry"},      carry_out, ec);
        check({name, " overflow"},   overflow, ev);
        check({name, " in_ready"},   in_ready, 0);
    endtask

    // Driver: one full operation, with `stall` cycles of out_ready low in HOLD.
    task automatic do_op(input logic [W-1:0] a, b, input logic sub,
                         input logic [W-1:0] es, input logic ec, ev,
                         input int stall, input string name);
        int t0;
        for (int k = 0; k < 40; k++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        check({name, " ready"}, in_ready, 1);
        op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
        out_ready = (stall == 0);
        t0 = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(t0, es, ec, ev, name);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check({name, " stall valid"}, out_valid, 1);
            check({name, " stall sum"},   sum, es);
            check({name, " stall ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({name, " released"}, out_valid, 0);
        check({name, " idle"},     in_ready, 1);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        logic         sub;
        logic [W-1:0] s;
        logic         c, v;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int t0, t1, n_acc, nload;
        int acc[3];
        logic [W-1:0] es, ra, rb;
        logic ec, ev, rs;
        logic [RW-1:0] e;

        tbl[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; op_sub = 1'b0;
        repeat (3) @(negedge clk);
        check("reset sr_load",   sr_load, 0);
        check("reset out_valid", out_valid, 0);
        check("reset busy",      busy, 0);
        check("reset sum",       sum, 0);
        check("reset carry",     carry_out, 0);
        check("reset overflow",  overflow, 0);
        check("reset data_a",    sr_data_a, 0);
        check("reset data_b",    sr_data_b, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", in_ready, 1);

        for (int i = 0; i < 5; i++)
            do_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].s, tbl[i].c, tbl[i].v, 0,
                  $sformatf("vec%0d", i));

        // Backpressure with a pending request queued behind HOLD.
        op_a = 8'h12; op_b = 8'h34; op_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        t0 = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(t0, 8'h46, 1'b0, 1'b0, "bp first");
        op_a = 8'h05; op_b = 8'h03; op_sub = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp valid", out_valid, 1);
            check("bp sum",   sum, 8'h46);
            check("bp ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp back to idle", in_ready, 1);
        check("bp valid low",    out_valid, 0);
        t1 = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(t1, 8'h02, 1'b1, 1'b0, "bp pending");
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of SHIFT.
        op_a = 8'h55; op_b = 8'h0F; op_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        t0 = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        while (cyc < t0 + 7) @(negedge clk);
        check("mid-shift busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid rst sr_load",   sr_load, 0);
        check("mid rst out_valid", out_valid, 0);
        check("mid rst busy",      busy, 0);
        check("mid rst sum",       sum, 0);
        check("mid rst carry",     carry_out, 0);
        check("mid rst overflow",  overflow, 0);
        check("mid rst data_a",    sr_data_a, 0);
        rst = 1'b0;
        @(negedge clk);
        check("mid rst in_ready", in_ready, 1);
        out_ready = 1'b0;
        do_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 0, "after reset");

        // Back-to-back with in_valid and out_ready held high.
        ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
        op_a = ra; op_b = rb; op_sub = rs; in_valid = 1'b1; out_ready = 1'b1;
        n_acc = 0; nload = 0;
        for (int k = 0; k < 36; k++) begin
            if (sr_load) nload++;
            if (out_valid) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("b2b sum",      sum, e[W-1:0]);
                    check("b2b carry",    carry_out, e[W]);
                    check("b2b overflow", overflow, e[W+1]);
                end else begin
                    check("b2b spurious out_valid", out_valid, 0);
                end
            end
            if (in_valid && in_ready) begin
                model(op_a, op_b, op_sub, es, ec, ev);
                exp_q.push_back({ev, ec, es});
                if (n_acc < 3) acc[n_acc] = cyc;
                n_acc++;
            end else if (!in_ready) begin
                op_a = W'($urandom); op_b = W'($urandom); op_sub = 1'($urandom);
            end
            if (k == 35) in_valid = 1'b0;
            @(negedge clk);
        end
        check("b2b accepts",    n_acc, 3);
        check("b2b loads",      nload, 3);
        check("b2b gap 1",      acc[1] - acc[0], W + 4);
        check("b2b gap 2",      acc[2] - acc[1], W + 4);
        check("b2b drained",    exp_q.size(), 0);
        check("b2b idle",       in_ready, 1);
        out_ready = 1'b0;

        // Random operations against the model, with random backpressure.
        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, es, ec, ev);
            do_op(ra, rb, rs, es, ec, ev, $urandom_range(0, 3), $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
